// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS load/store port.
// Accepts one word-addressed request at a time, commits it after LATENCY wait states and
// presents the result until the initiator consumes it. Storage is not affected by Reset.
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned Words   = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    accept, commit;

    // Request captured at acceptance; held while the request is in flight.
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [3:0]              be_q;
    logic [31:0]             wdata_q;
    logic                    oor_q;

    logic [31:0]             mem [Words];

    // Byte-offset bits are ignored; the initiator handles sub-word alignment.
    logic                    unused_addr;
    assign unused_addr = ^req_addr[1:0];

    // Next-state, countdown and response-data selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        accept  = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = CntInit;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    commit  = 1'b1;
                    state_d = StResp;
                    err_d   = oor_q;
                    rdata_d = (oor_q || we_q) ? 32'd0 : mem[idx_q];
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and response registers; Reset wins over any commit on the same edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Latch the request fields when it is accepted; later req_* activity is ignored.
    always_ff @(posedge Clk) begin
        if (accept) begin
            we_q    <= req_we;
            idx_q   <= req_addr[ADDR_WIDTH+1:2];
            be_q    <= req_be;
            wdata_q <= req_wdata;
            oor_q   <= |req_addr[31:ADDR_WIDTH+2];
        end
    end

    // Byte-enabled write at commit; out-of-range and reset-aborted writes never land.
    always_ff @(posedge Clk) begin
        if (!Reset && commit && we_q && !oor_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
